// File: rtl/lsu_mem_port.sv
// Load/store port between the pipeline memory stage and a word-wide data RAM.
// Handles one request at a time: loads extract and extend a byte, a halfword
// or a full word. Sub-word stores read the RAM word, merge the new lanes into
// it, then write the word back. Bad requests are answered with an error and
// never reach the RAM.
module lsu_mem_port #(
    parameter int ADDR_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged_q, merged_d;
    logic        err_q, err_d;

    logic        funct_bad;
    logic        misaligned;
    logic        out_of_window;
    logic        req_bad;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Classify the incoming request: illegal width, misalignment or out-of-window address
    always_comb begin
        funct_bad     = 1'b0;
        misaligned    = 1'b0;
        out_of_window = ((req_addr >> (ADDR_LEN + 2)) != 32'd0);
        if (req_we) begin
            funct_bad = !((req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010));
        end else begin
            funct_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_bad = funct_bad || misaligned || out_of_window;
    end

    // Pick the addressed byte/half lanes out of the RAM word and extend them for loads
    always_comb begin
        sel_byte = ram_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   sel_byte = ram_rdata[7:0];
            2'b01:   sel_byte = ram_rdata[15:8];
            2'b10:   sel_byte = ram_rdata[23:16];
            default: sel_byte = ram_rdata[31:24];
        endcase
        sel_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = ram_rdata;
        endcase
    end

    // Build the read-modify-write word for sub-word stores (little-endian lanes)
    always_comb begin
        merged_word = ram_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged_word[7:0]   = wdata_q[7:0];
                2'b01:   merged_word[15:8]  = wdata_q[7:0];
                2'b10:   merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged_word[31:16] = wdata_q[15:0];
        end else begin
            merged_word[15:0] = wdata_q[15:0];
        end
    end

    // Next-state logic: accept in IDLE, touch RAM in ACCESS/WRITE, hold the response in RESP
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;
        err_d    = err_q;
        ram_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = req_bad;
                    state_d  = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (funct3_q == 3'b010) begin
                    ram_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    merged_d = merged_word;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                ram_we  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset returns the port to a clean idle state at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            merged_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_addr   = {addr_q[31:2], 2'b00};
    assign ram_wdata  = (state_q == WRITE) ? merged_q : wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural word RAM attached.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:65535];

    int assertCount = 0;
    int failCount   = 0;

    lsu_mem_port #(.ADDR_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, synchronous word write
    assign ram_rdata = mem[ram_addr[17:2]];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[17:2]] <= ram_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one request and return #1 after the edge that accepted it
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Full transaction: latency, write-enable cycles, data, error and handshake
    task automatic runOp(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int expLat, input logic [31:0] expRdata,
                         input logic expErr, input int expWe);
        int  cycles;
        int  weCount;
        bit  done;
        applyStimulus(we, f3, addr, wdata);
        cycles  = 1;
        weCount = 0;
        done    = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ram_we) weCount++;
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        checkOutput({tag, "_latency"}, cycles, done ? expLat : -1);
        checkOutput({tag, "_rdata"}, resp_rdata, expRdata);
        checkOutput({tag, "_err"}, {31'd0, resp_err}, {31'd0, expErr});
        checkOutput({tag, "_we_cycles"}, weCount, expWe);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        mem[4] = 32'h8081_F2F3;
        mem[8] = 32'h1122_3344;
        #2;

        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("rst_ram_addr", ram_addr, 32'd0);
        checkOutput("rst_ram_wdata", ram_wdata, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load extension
        runOp("lb_13",  1'b0, 3'b000, 32'h13, 32'd0, 2, 32'hFFFF_FF80, 1'b0, 0);
        runOp("lbu_13", 1'b0, 3'b100, 32'h13, 32'd0, 2, 32'h0000_0080, 1'b0, 0);
        runOp("lh_10",  1'b0, 3'b001, 32'h10, 32'd0, 2, 32'hFFFF_F2F3, 1'b0, 0);
        runOp("lhu_12", 1'b0, 3'b101, 32'h12, 32'd0, 2, 32'h0000_8081, 1'b0, 0);

        // Reset while a byte store sits in WRITE
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h0000_00AB);
        @(posedge clk);
        #1;
        checkOutput("wr_state_we", {31'd0, ram_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("mid_rst_ram_addr", ram_addr, 32'd0);
        checkOutput("mid_rst_ram_wdata", ram_wdata, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_ram_kept", mem[8], 32'h1122_3344);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);

        // Sub-word stores
        runOp("sb_21", 1'b1, 3'b000, 32'h21, 32'h0000_00AB, 3, 32'd0, 1'b0, 1);
        checkOutput("sb_21_ram", mem[8], 32'h1122_AB44);
        runOp("sh_22", 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 3, 32'd0, 1'b0, 1);
        checkOutput("sh_22_ram", mem[8], 32'hBEEF_AB44);

        // Word store then read back
        runOp("sw_40", 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 1);
        checkOutput("sw_40_ram", mem[16], 32'hDEAD_BEEF);
        runOp("lw_40", 1'b0, 3'b010, 32'h40, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, 0);

        // Rejected requests
        runOp("err_lh_11",  1'b0, 3'b001, 32'h11, 32'd0, 1, 32'd0, 1'b1, 0);
        runOp("err_lw_42",  1'b0, 3'b010, 32'h42, 32'd0, 1, 32'd0, 1'b1, 0);
        runOp("err_sw_win", 1'b1, 3'b010, 32'h0004_0000, 32'h1234_5678, 1, 32'd0, 1'b1, 0);
        runOp("err_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 1, 32'd0, 1'b1, 0);
        checkOutput("err_ram_w0", mem[0], 32'd0);
        checkOutput("err_ram_w4", mem[4], 32'h8081_F2F3);
        checkOutput("err_ram_w8", mem[8], 32'hBEEF_AB44);
        checkOutput("err_ram_w16", mem[16], 32'hDEAD_BEEF);

        // Backpressure with a second request waiting
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("bp_rdata", resp_rdata, 32'h8081_F2F3);
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("bp_after_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("bp_after_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("bp_second_accepted", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_second_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("bp_second_rdata", resp_rdata, 32'hBEEF_AB44);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("bp_final_ready", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store port between the pipeline's memory stage and the data RAM (synchronous word write, combinational word read, word-indexed by addr[ADDR_LEN+1:2]). Accepts one load or store at a time over a valid/ready handshake. Performs byte/halfword extraction with sign or zero extension on loads, and read-modify-write merging on sub-word stores. Rejects misaligned, illegal-width and out-of-window accesses without touching RAM.

## Interface
- ADDR_LEN, 16, word-index width of the RAM; the legal byte window is [0, 4*2^ADDR_LEN).
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  port idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores use only 000, 001, 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte, low half or full word is used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM byte address; always word-aligned (bits [1:0] = 0).
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM combinational read data for ram_addr.

## Operation
- States: IDLE, ACCESS, WRITE, RESP. req_ready = (state == IDLE).
- IDLE: when req_valid is high, latch we, funct3, addr and wdata, then check the request.
  - Error if funct3 is illegal for its direction (load 011/110/111; store anything other than 000/001/010).
  - Error if misaligned (half with addr[0] = 1; word with addr[1:0] ≠ 0).
  - Error if addr[31:ADDR_LEN+2] ≠ 0.
  - On error: go to RESP with err = 1. No RAM cycle.
  - Otherwise go to ACCESS.
- ACCESS: ram_addr = {addr[31:2], 2'b00}.
  - Load: extract the byte or half selected by addr[1:0] from ram_rdata, extend it (lb/lh sign, lbu/lhu zero), register it into resp_rdata, go to RESP.
  - sw: ram_we = 1 and ram_wdata = wdata this cycle, go to RESP.
  - sb/sh: register the merged word (ram_rdata with the selected byte/half lanes replaced by wdata[7:0] or wdata[15:0]), go to WRITE.
- WRITE: ram_we = 1 and ram_wdata = merged word, at the same ram_addr. Go to RESP.
- RESP: resp_valid = 1, outputs held stable. When resp_ready is high, go to IDLE.
- ram_we is high only in ACCESS (sw) and WRITE. It is combinational from state, so it is never high in IDLE or RESP.
- Lane mapping is little-endian: byte k = bits [8k+7:8k]; half at addr[1] = 1 is bits [31:16].

## Timing
- Reset (async, immediate): state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, ram_we 0, ram_addr 0, ram_wdata 0.
- Request accepted at edge T (IDLE with req_valid high).
  - Load or sw: ACCESS in cycle T+1, resp_valid from T+2. sw commits to RAM at the edge ending T+1.
  - sb/sh: ACCESS T+1, WRITE T+2, resp_valid from T+3. RAM updates at the edge ending T+2.
  - Error: resp_valid from T+1.
- Response handshake completes at the edge where resp_valid and resp_ready are both high. req_ready rises the following cycle; there is no back-to-back accept in the same cycle as the response.
- Stalled resp_ready: stay in RESP indefinitely with no further RAM writes.
- Reset asserted mid-operation: return to IDLE immediately and drop ram_we. A sub-word store reset in WRITE before its edge leaves RAM unchanged. No partial response is emitted.
- ram_addr and ram_wdata are registered or held between operations, never X after reset.

## Test plan
- Load extension: preload word 0x8081_F2F3 at byte address 0x10.
  - lb 0x13 → resp_rdata 0xFFFF_FF80.
  - lbu 0x13 → 0x0000_0080.
  - lh 0x10 → 0xFFFF_F2F3.
  - lhu 0x12 → 0x0000_8081.
  - Each response arrives 2 cycles after accept.
- Sub-word store: RAM[0x20] = 0x1122_3344. sb 0x21 with wdata 0xAB → RAM 0x1122_AB44; sh 0x22 with wdata 0xBEEF → 0xBEEF_AB44. ram_we is high exactly 1 cycle (WRITE) per store; resp_valid arrives 3 cycles after accept.
- sw 0x40 with 0xDEAD_BEEF → RAM word index 0x10 = 0xDEADBEEF, ram_we high only in ACCESS, response after 2 cycles. A following lw 0x40 returns 0xDEADBEEF.
- Errors: lh 0x11, lw 0x42, sw 0x0004_0000 (ADDR_LEN 16), load funct3 011.
  - Each → resp_err 1, resp_rdata 0, response 1 cycle after accept.
  - ram_we never asserted; RAM contents unchanged.
- Backpressure: hold resp_ready 0 for 5 cycles after resp_valid. resp_valid and data stay stable, req_ready stays 0, and a req_valid presented meanwhile is not accepted until the cycle after the handshake.
- Reset in WRITE during sb 0x21: pull rst_n low before the edge. Outputs return to reset values immediately, RAM[0x20] stays 0x1122_3344, and after release req_ready is 1 with no resp_valid.
